// File: rtl/banco_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// banco_pkg : shared constants and read-port record for the banco register file
// Rev 1.0
// ----------------------------------------------------------------------------
package banco_pkg;

  localparam int BANCO_M = 8;
  localparam int BANCO_N = 4;

  typedef struct packed {
    logic [BANCO_M-1:0] data;
    logic               vld;
  } banco_rd_t;

endpackage
`default_nettype wire

// File: rtl/banco_rdport.sv
`default_nettype none
// ----------------------------------------------------------------------------
// banco_rdport : registered read port (mux, write-collision bypass, rv strobe)
// Optional feature macro: BANCO_BYPASS_EN (write-first collisions). Rev 1.0
// ----------------------------------------------------------------------------
module banco_rdport
  import banco_pkg::*;
#(
  parameter int M        = BANCO_M,
  parameter int N        = BANCO_N,
  parameter int ZERO_REG = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ren,
  input  logic [N-1:0]   addr,
  input  logic [M-1:0]   mem [2**N],
  input  logic [2**N-1:0] valid,
  input  logic           wrt,
  input  logic [N-1:0]   waddr,
  input  logic [M-1:0]   wdata,
  output logic [M-1:0]   rd_data,
  output logic           rd_vld,
  output logic           rv
);

  logic [M-1:0] next_data;
  logic         next_vld;
  logic         zero_hit;

  assign zero_hit = (ZERO_REG != 0) && (addr == '0);

  // zero_hit is checked first so a hardwired register 0 never bypasses
  always_comb begin
    next_data = mem[addr];
    next_vld  = valid[addr];
    if (zero_hit) begin
      next_data = '0;
      next_vld  = 1'b1;
    end
`ifdef BANCO_BYPASS_EN
    else if (wrt && (waddr == addr)) begin
      next_data = wdata;
      next_vld  = 1'b1;
    end
`endif
  end

`ifndef BANCO_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wrt, waddr, wdata};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
      rv      <= 1'b0;
    end else begin
      rv <= ren;
      if (ren) begin
        rd_data <= next_data;
        rd_vld  <= next_vld;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/banco_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// banco_pipe : 1W/2R register file with registered reads and per-entry valid
// Optional feature macro: BANCO_BYPASS_EN (write-first collisions). Rev 1.0
// ----------------------------------------------------------------------------
module banco_pipe
  import banco_pkg::*;
#(
  parameter int M        = BANCO_M,
  parameter int N        = BANCO_N,
  parameter int ZERO_REG = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wrt,
  input  logic [N-1:0] waddr,
  input  logic [M-1:0] Min,
  input  logic         ren1,
  input  logic         ren2,
  input  logic [N-1:0] addr1,
  input  logic [N-1:0] addr2,
  output logic [M-1:0] Mout1,
  output logic [M-1:0] Mout2,
  output logic         rv1,
  output logic         rv2,
  output logic         vld1,
  output logic         vld2
);

  localparam int DEPTH = 2**N;

  logic [M-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             write_ok;

  assign write_ok = wrt && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (write_ok) begin
      mem[waddr]   <= Min;
      valid[waddr] <= 1'b1;
    end
  end

  banco_rdport #(.M(M), .N(N), .ZERO_REG(ZERO_REG)) u_rd1 (
    .clk     (clk),
    .rst     (rst),
    .ren     (ren1),
    .addr    (addr1),
    .mem     (mem),
    .valid   (valid),
    .wrt     (wrt),
    .waddr   (waddr),
    .wdata   (Min),
    .rd_data (Mout1),
    .rd_vld  (vld1),
    .rv      (rv1)
  );

  banco_rdport #(.M(M), .N(N), .ZERO_REG(ZERO_REG)) u_rd2 (
    .clk     (clk),
    .rst     (rst),
    .ren     (ren2),
    .addr    (addr2),
    .mem     (mem),
    .valid   (valid),
    .wrt     (wrt),
    .waddr   (waddr),
    .wdata   (Min),
    .rd_data (Mout2),
    .rd_vld  (vld2),
    .rv      (rv2)
  );

endmodule
`default_nettype wire

// File: tb/tb_banco_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_banco_pipe : directed table-driven bench for banco_pipe (ZERO_REG 0 and 1)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_banco_pipe;
  import banco_pkg::*;

`ifdef BANCO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, wrt, ren1, ren2;
  logic [3:0] waddr, addr1, addr2;
  logic [7:0] min;
  logic [7:0] mout1, mout2, z_mout1, z_mout2;
  logic       rv1, rv2, vld1, vld2, z_rv1, z_rv2, z_vld1, z_vld2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  banco_pipe #(.M(8), .N(4), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .wrt(wrt), .waddr(waddr), .Min(min),
    .ren1(ren1), .ren2(ren2), .addr1(addr1), .addr2(addr2),
    .Mout1(mout1), .Mout2(mout2), .rv1(rv1), .rv2(rv2), .vld1(vld1), .vld2(vld2)
  );

  banco_pipe #(.M(8), .N(4), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .wrt(wrt), .waddr(waddr), .Min(min),
    .ren1(ren1), .ren2(ren2), .addr1(addr1), .addr2(addr2),
    .Mout1(z_mout1), .Mout2(z_mout2), .rv1(z_rv1), .rv2(z_rv2), .vld1(z_vld1), .vld2(z_vld2)
  );

  typedef struct {
    logic      rst, wrt;
    logic [3:0] wa;
    logic [7:0] wd;
    logic      r1;
    logic [3:0] a1;
    logic      r2;
    logic [3:0] a2;
    banco_rd_t e1, e2;
    logic      erv1, erv2;
    banco_rd_t z1;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic w, input int wa, input int wd,
                              input logic r1, input int a1, input logic r2, input int a2,
                              input int d1, input logic v1, input logic rv1e,
                              input int d2, input logic v2, input logic rv2e);
    vec_t v;
    v.rst = r;  v.wrt = w;  v.wa = 4'(wa);  v.wd = 8'(wd);
    v.r1 = r1;  v.a1 = 4'(a1);  v.r2 = r2;  v.a2 = 4'(a2);
    v.e1.data = 8'(d1);  v.e1.vld = v1;  v.erv1 = rv1e;
    v.e2.data = 8'(d2);  v.e2.vld = v2;  v.erv2 = rv2e;
    v.z1 = v.e1;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic w, input int wa, input int wd,
                       input logic r1, input int a1, input logic r2, input int a2);
    @(negedge clk);
    rst = r;  wrt = w;  waddr = 4'(wa);  min = 8'(wd);
    ren1 = r1;  addr1 = 4'(a1);  ren2 = r2;  addr2 = 4'(a2);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[14];
  int   rv_cnt;

  initial begin
    rst = 1'b1; wrt = 1'b0; waddr = '0; min = '0;
    ren1 = 1'b0; ren2 = 1'b0; addr1 = '0; addr2 = '0;

    //          rst wrt wa  wd     r1 a1 r2 a2   d1 v1 rv1               d2 v2 rv2
    vecs[0]  = mk(1, 0, 0, 0,     0, 0, 0, 0,   0, 0, 0,                0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0,     0, 0, 0, 0,   0, 0, 0,                0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0,     1, 5, 0, 0,   0, 0, 1,                0, 0, 0);
    vecs[3]  = mk(0, 1, 7, 127,   0, 0, 0, 0,   0, 0, 0,                0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0,     1, 7, 1, 7,   127, 1, 1,              127, 1, 1);
    vecs[5]  = mk(0, 1, 8, 255,   0, 0, 1, 8,   127, 1, 0,              BYP ? 255 : 0, BYP, 1);
    vecs[6]  = mk(0, 0, 0, 0,     1, 8, 1, 8,   255, 1, 1,              255, 1, 1);
    vecs[7]  = mk(0, 1, 3, 'hAA,  0, 0, 0, 0,   255, 1, 0,              255, 1, 0);
    vecs[8]  = mk(1, 1, 3, 'h55,  1, 3, 0, 0,   0, 0, 0,                0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0,     1, 3, 1, 8,   0, 0, 1,                0, 0, 1);
    vecs[10] = mk(0, 1, 2, 'h11,  1, 2, 1, 3,   BYP ? 'h11 : 0, BYP, 1, 0, 0, 1);
    vecs[11] = mk(0, 1, 2, 'h22,  1, 2, 0, 0,   BYP ? 'h22 : 'h11, 1, 1, 0, 0, 0);
    vecs[12] = mk(0, 1, 0, 99,    0, 0, 0, 0,   BYP ? 'h22 : 'h11, 1, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0,     1, 0, 1, 2,   99, 1, 1,               'h22, 1, 1);
    // register 0 is hardwired on dut_z: the write of 99 is dropped, reads give 0 valid
    vecs[13].z1.data = 8'd0;
    vecs[13].z1.vld  = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].wrt, int'(vecs[i].wa), int'(vecs[i].wd),
            vecs[i].r1, int'(vecs[i].a1), vecs[i].r2, int'(vecs[i].a2));
      chk($sformatf("row%0d mout1", i), int'(mout1), int'(vecs[i].e1.data));
      chk($sformatf("row%0d vld1", i),  int'(vld1),  int'(vecs[i].e1.vld));
      chk($sformatf("row%0d rv1", i),   int'(rv1),   int'(vecs[i].erv1));
      chk($sformatf("row%0d mout2", i), int'(mout2), int'(vecs[i].e2.data));
      chk($sformatf("row%0d vld2", i),  int'(vld2),  int'(vecs[i].e2.vld));
      chk($sformatf("row%0d rv2", i),   int'(rv2),   int'(vecs[i].erv2));
      chk($sformatf("row%0d z_mout1", i), int'(z_mout1), int'(vecs[i].z1.data));
      chk($sformatf("row%0d z_vld1", i),  int'(z_vld1),  int'(vecs[i].z1.vld));
    end

    // single read pulse, then the register keeps changing while ren1 stays low
    rv_cnt = 0;
    drive(0, 0, 0, 0, 1, 2, 0, 0);
    rv_cnt += int'(rv1);
    chk("hold pulse mout1", int'(mout1), 'h22);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 2, 'h33 + k * 'h11, 0, 2, 0, 0);
      rv_cnt += int'(rv1);
      chk($sformatf("hold%0d mout1", k), int'(mout1), 'h22);
      chk($sformatf("hold%0d rv1", k),   int'(rv1),   0);
    end
    chk("hold rv1 pulses", rv_cnt, 1);
    drive(0, 0, 0, 0, 1, 2, 0, 0);
    chk("after hold mout1", int'(mout1), 'h55);

    // collision on address 0: bypass applies only where register 0 is writable
    drive(0, 1, 0, 77, 1, 0, 1, 0);
    chk("col0 mout1",   int'(mout1),   BYP ? 77 : 99);
    chk("col0 mout2",   int'(mout2),   BYP ? 77 : 99);
    chk("col0 z_mout1", int'(z_mout1), 0);
    chk("col0 z_vld1",  int'(z_vld1),  1);
    chk("col0 z_mout2", int'(z_mout2), 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    chk("rd0 mout1",   int'(mout1),   77);
    chk("rd0 z_mout1", int'(z_mout1), 0);

    // read accepted, then reset on the next edge kills the strobe
    drive(0, 0, 0, 0, 1, 7, 0, 0);
    chk("pre-rst rv1", int'(rv1), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst rv1",   int'(rv1),   0);
    chk("rst mout1", int'(mout1), 0);
    chk("rst vld1",  int'(vld1),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/banco_pipe.md
BANCO_PIPE -- requirements
Module: banco_pipe

Interface
REQ-001 Parameter M, default 8, data word width in bits (M >= 1).
REQ-002 Parameter N, default 4, address width; depth = 2**N registers.
REQ-003 Parameter ZERO_REG, default 0; 1 = register 0 hardwired to zero.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wrt  input  1  write enable.
REQ-007 waddr  input  N  write address.
REQ-008 Min  input  M  write data.
REQ-009 ren1, ren2  input  1 each  read enable, port 1 / port 2.
REQ-010 addr1, addr2  input  N each  read address, port 1 / port 2.
REQ-011 Mout1, Mout2  output  M each  registered read data.
REQ-012 rv1, rv2  output  1 each  read-valid strobe, one cycle after an accepted read.
REQ-013 vld1, vld2  output  1 each  addressed register written since reset; sampled with Mout.

Function
REQ-014 Write: on edge with wrt=1 and rst=0, reg[waddr] <= Min and valid[waddr] <= 1.
REQ-015 Read latency is exactly 1 cycle: edge with renK=1 loads MoutK, vldK from addrK and sets rvK=1.
REQ-016 When renK=0, MoutK and vldK hold their previous values and rvK=0 on the next cycle.
REQ-017 Both read ports are independent and may address the same register in the same cycle; both return identical data.
REQ-018 Write to the same address as a same-cycle read: behaviour per REQ-025/026.
REQ-019 ZERO_REG=1: writes to address 0 are ignored; reads of address 0 return 0 with vld=1.
REQ-020 Unwritten registers read as 0 with vld=0.

Reset
REQ-021 rst=1 at an edge clears every register to 0 and every valid bit to 0.
REQ-022 rst=1 at an edge sets Mout1=Mout2=0, rv1=rv2=0, vld1=vld2=0.
REQ-023 rst has priority over wrt and renK in the same cycle; the write is dropped and no rv strobe follows.
REQ-024 Reset between a read edge and the following cycle forces rv low; the read is lost.

Configuration
REQ-025 With macro BANCO_BYPASS_EN defined: a read with addrK == waddr and wrt=1 in the same cycle returns Min with vld=1 (write-first), except waddr=0 under ZERO_REG=1.
REQ-026 Without BANCO_BYPASS_EN: the same collision returns the pre-write contents and valid bit (read-first); the new value is visible from the next read.

Structure
REQ-027 Shared package banco_pkg holds default constants BANCO_M=8, BANCO_N=4 and the read-port typedef (data, vld).
REQ-028 One sub-module, banco_rdport, implements a registered read port (mux, bypass compare, output registers, rv strobe) and is instantiated twice.
REQ-029 Storage array and valid bits live in banco_pipe; no other hierarchy.

Verification (M=8, N=4)
REQ-030 rst 2 cycles, then ren1=1 addr1=5 -> next cycle Mout1=0, vld1=0, rv1=1.
REQ-031 wrt=1 waddr=7 Min=127; next cycle ren1=1 addr1=7, ren2=1 addr2=7 -> Mout1=Mout2=127, vld1=vld2=1, rv1=rv2=1.
REQ-032 wrt=1 waddr=8 Min=255 with ren2=1 addr2=8 same cycle -> Mout2=255 vld2=1 if BANCO_BYPASS_EN, else Mout2=0 vld2=0; the following read of address 8 returns 255 in both builds.
REQ-033 ZERO_REG=1: wrt=1 waddr=0 Min=99; read addr1=0 -> Mout1=0, vld1=1.
REQ-034 Fill reg 3=0xAA, assert rst together with wrt=1 waddr=3 Min=0x55 and ren1=1 -> outputs 0, rv1=0; later read of address 3 -> 0, vld1=0.
REQ-035 ren1 pulsed once then held low 3 cycles while reg changes -> Mout1 holds the first value, rv1 high exactly one cycle.
